ex_mem_stage: RTL and testbench

//  EX->MEM pipeline stage directly downstream of the 64-bit ALU. Captures ALU

---
 rtl/ex_mem_pkg.sv | 32 +++
 rtl/ex_mem_if.sv | 64 ++++++
 rtl/ex_mem_branch_resolve.sv | 24 ++
 rtl/ex_mem_stage.sv | 144 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and encodings for the EX->MEM stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_mem_pkg;

   // Datapath widths used by every file of the stage
   localparam int XLEN    = 64;
   localparam int RADDR_W = 5;

   // branch_op encodings
   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_NE   = 2'b10;
   localparam logic [1:0] BR_GT   = 2'b11;

   // Skid-buffer occupancy states
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Bundle held in the main and skid slots
   typedef struct packed {
      logic [XLEN-1:0]    alu_result;
      logic [XLEN-1:0]    store_data;
      logic [RADDR_W-1:0] rd;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
   } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_if.sv
// Handshake bundles on either side of the EX->MEM stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carried alongside the valids.

// EX side: master is the ALU stage, slave is the EX->MEM register
interface ex_mem_in_if;
   import ex_mem_pkg::*;
   logic               in_valid;
   logic               in_ready;
   logic [XLEN-1:0]    alu_result;
   logic               alu_zero;
   logic               alu_a_bgt_b;
   logic [XLEN-1:0]    rs2_data;
   logic [XLEN-1:0]    branch_target;
   logic [RADDR_W-1:0] rd;
   logic [1:0]         branch_op;
   logic               mem_read;
   logic               mem_write;
   logic               reg_write;
   logic               mem_to_reg;
   logic               flush;

   modport master (
      output in_valid, alu_result, alu_zero, alu_a_bgt_b, rs2_data,
             branch_target, rd, branch_op, mem_read, mem_write,
             reg_write, mem_to_reg, flush,
      input  in_ready
   );
   modport slave (
      input  in_valid, alu_result, alu_zero, alu_a_bgt_b, rs2_data,
             branch_target, rd, branch_op, mem_read, mem_write,
             reg_write, mem_to_reg, flush,
      output in_ready
   );
endinterface

// MEM side: master is the EX->MEM register, slave is the memory stage
interface ex_mem_out_if;
   import ex_mem_pkg::*;
   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_alu_result;
   logic [XLEN-1:0]    out_store_data;
   logic [RADDR_W-1:0] out_rd;
   logic               out_mem_read;
   logic               out_mem_write;
   logic               out_reg_write;
   logic               out_mem_to_reg;
   logic               pc_src;
   logic [XLEN-1:0]    pc_target;

   modport master (
      output out_valid, out_alu_result, out_store_data, out_rd,
             out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
             pc_src, pc_target,
      input  out_ready
   );
   modport slave (
      input  out_valid, out_alu_result, out_store_data, out_rd,
             out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
             pc_src, pc_target,
      output out_ready
   );
endinterface

// File: rtl/ex_mem_branch_resolve.sv
// Branch decision from ALU flags and branch_op.
// Latency: combinational.
// Backpressure: none.
module ex_mem_branch_resolve
   import ex_mem_pkg::*;
(
   input  logic [1:0] branch_op,
   input  logic       zero,
   input  logic       a_bgt_b,
   output logic       taken
);

   // BR_NONE never redirects the PC
   always_comb begin
      taken = 1'b0;
      case (branch_op)
         BR_EQ:   taken = zero;
         BR_NE:   taken = !zero;
         BR_GT:   taken = a_bgt_b;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM register with a 2-entry skid buffer and branch resolution (optional EX_MEM_PERF_EN counters).
// Latency: 1 cycle in->out when empty; pc_src pulses 1 cycle after accept, independent of out_ready.
// Backpressure: in_ready is registered and drops only when both slots are occupied; flush empties both.
module ex_mem_stage
   import ex_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   ex_mem_in_if.slave  ex,
   ex_mem_out_if.master mem
`ifdef EX_MEM_PERF_EN
   ,
   output logic [31:0] perf_taken_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   logic [1:0]      state, state_d;
   logic            in_ready_q;
   ex_mem_entry_t   main_q, main_d;
   ex_mem_entry_t   skid_q, skid_d;
   ex_mem_entry_t   in_entry;
   logic            pc_src_q;
   logic [XLEN-1:0] pc_target_q;
   logic            accept, transfer, out_valid, taken;

   assign in_entry.alu_result = ex.alu_result;
   assign in_entry.store_data = ex.rs2_data;
   assign in_entry.rd         = ex.rd;
   assign in_entry.mem_read   = ex.mem_read;
   assign in_entry.mem_write  = ex.mem_write;
   assign in_entry.reg_write  = ex.reg_write;
   assign in_entry.mem_to_reg = ex.mem_to_reg;

   assign out_valid = (state != ST_EMPTY);
   assign accept    = ex.in_valid & in_ready_q;
   assign transfer  = out_valid & mem.out_ready;

   ex_mem_branch_resolve u_br (
      .branch_op (ex.branch_op),
      .zero      (ex.alu_zero),
      .a_bgt_b   (ex.alu_a_bgt_b),
      .taken     (taken)
   );

   // Slot/state update; vacated slots are zeroed so invalid entries read as 0
   always_comb begin
      state_d = state;
      main_d  = main_q;
      skid_d  = skid_q;
      if (ex.flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = in_entry;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && !transfer) begin
                  skid_d  = in_entry;
                  state_d = ST_FULL;
               end else if (transfer && !accept) begin
                  main_d  = '0;
                  state_d = ST_EMPTY;
               end else if (accept && transfer) begin
                  main_d  = in_entry;
               end
            end
            ST_FULL: begin
               if (transfer) begin
                  main_d  = skid_q;
                  skid_d  = '0;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   // Register slots, state and the look-ahead in_ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state      <= state_d;
         in_ready_q <= (state_d != ST_FULL);
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   // Taken-branch pulse; a flushed input never redirects the PC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_src_q    <= 1'b0;
         pc_target_q <= '0;
      end else if (accept && taken && !ex.flush) begin
         pc_src_q    <= 1'b1;
         pc_target_q <= ex.branch_target;
      end else begin
         pc_src_q    <= 1'b0;
         pc_target_q <= '0;
      end
   end

`ifdef EX_MEM_PERF_EN
   // Free-running event counters, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_taken_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         perf_taken_cnt <= perf_taken_cnt + {31'd0, pc_src_q};
         perf_stall_cnt <= perf_stall_cnt + {31'd0, out_valid & !mem.out_ready};
      end
   end
`endif

   assign ex.in_ready       = in_ready_q;
   assign mem.out_valid      = out_valid;
   assign mem.out_alu_result = main_q.alu_result;
   assign mem.out_store_data = main_q.store_data;
   assign mem.out_rd         = main_q.rd;
   assign mem.out_mem_read   = main_q.mem_read;
   assign mem.out_mem_write  = main_q.mem_write;
   assign mem.out_reg_write  = main_q.reg_write;
   assign mem.out_mem_to_reg = main_q.mem_to_reg;
   assign mem.pc_src         = pc_src_q;
   assign mem.pc_target      = pc_target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized + directed bench for ex_mem_stage with a queue-based reference model.
// Latency: checks sampled on the falling edge; stimulus driven 1ns after the rising edge.
// Backpressure: out_ready randomized; upstream holds an offer until accepted or flushed.
module tb_ex_mem_stage;
   import ex_mem_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_mem_in_if  ein ();
   ex_mem_out_if mout ();

`ifdef EX_MEM_PERF_EN
   logic [31:0] perf_taken_cnt, perf_stall_cnt;
`endif

   ex_mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .ex    (ein),
      .mem   (mout)
`ifdef EX_MEM_PERF_EN
      ,
      .perf_taken_cnt (perf_taken_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference model: entries held by the stage, oldest first
   ex_mem_entry_t   q[$];
   logic            exp_pc = 1'b0;
   logic [63:0]     exp_tgt = '0;
   logic [31:0]     m_taken = '0;
   logic [31:0]     m_stall = '0;
   logic            offer_done = 1'b1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Branch rule: BEQ on zero, BNE on !zero, BGT on a>b, none never
   function automatic logic ref_taken(input logic [1:0] op, input logic z, input logic gt);
      if (op == 2'b01) return z;
      if (op == 2'b10) return !z;
      if (op == 2'b11) return gt;
      return 1'b0;
   endfunction

   // Monitor: compares presented outputs with the model, then advances the model
   always @(negedge clk) begin
      ex_mem_entry_t f, e;
      logic acc, xfer;
      if (reset) begin
         chk("rst_out_valid", {63'd0, mout.out_valid}, 64'd0);
         chk("rst_in_ready", {63'd0, ein.in_ready}, 64'd1);
         chk("rst_pc_src", {63'd0, mout.pc_src}, 64'd0);
         chk("rst_pc_target", mout.pc_target, 64'd0);
         chk("rst_out_result", mout.out_alu_result, 64'd0);
         chk("rst_out_store", mout.out_store_data, 64'd0);
         chk("rst_out_ctl", {55'd0, mout.out_rd, mout.out_mem_read, mout.out_mem_write,
                             mout.out_reg_write, mout.out_mem_to_reg}, 64'd0);
`ifdef EX_MEM_PERF_EN
         chk("rst_perf_taken", {32'd0, perf_taken_cnt}, 64'd0);
         chk("rst_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
`endif
         q.delete();
         exp_pc     = 1'b0;
         exp_tgt    = '0;
         m_taken    = '0;
         m_stall    = '0;
         offer_done = 1'b1;
      end else begin
         chk("out_valid", {63'd0, mout.out_valid}, {63'd0, q.size() != 0});
         chk("in_ready", {63'd0, ein.in_ready}, {63'd0, q.size() < 2});
         chk("pc_src", {63'd0, mout.pc_src}, {63'd0, exp_pc});
         chk("pc_target", mout.pc_target, exp_tgt);
         f = (q.size() != 0) ? q[0] : '0;
         chk("out_alu_result", mout.out_alu_result, f.alu_result);
         chk("out_store_data", mout.out_store_data, f.store_data);
         chk("out_ctl", {55'd0, mout.out_rd, mout.out_mem_read, mout.out_mem_write,
                         mout.out_reg_write, mout.out_mem_to_reg},
                        {55'd0, f.rd, f.mem_read, f.mem_write, f.reg_write, f.mem_to_reg});
`ifdef EX_MEM_PERF_EN
         chk("perf_taken", {32'd0, perf_taken_cnt}, {32'd0, m_taken});
         chk("perf_stall", {32'd0, perf_stall_cnt}, {32'd0, m_stall});
`endif
         acc  = ein.in_valid && (q.size() < 2);
         xfer = (q.size() != 0) && mout.out_ready;
         if ((q.size() != 0) && !mout.out_ready) m_stall = m_stall + 1;
         if (exp_pc) m_taken = m_taken + 1;
         exp_pc  = acc && !ein.flush && ref_taken(ein.branch_op, ein.alu_zero, ein.alu_a_bgt_b);
         exp_tgt = exp_pc ? ein.branch_target : 64'd0;
         if (xfer) void'(q.pop_front());
         e.alu_result = ein.alu_result;
         e.store_data = ein.rs2_data;
         e.rd         = ein.rd;
         e.mem_read   = ein.mem_read;
         e.mem_write  = ein.mem_write;
         e.reg_write  = ein.reg_write;
         e.mem_to_reg = ein.mem_to_reg;
         if (ein.flush) q.delete();
         else if (acc) q.push_back(e);
         offer_done = !ein.in_valid || acc || ein.flush;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [63:0] res, input logic [4:0] rd, input logic [1:0] op,
                         input logic z, input logic gt, input logic [63:0] tgt,
                         input logic [63:0] sd, input logic [3:0] ctl);
      ein.in_valid      = 1'b1;
      ein.alu_result    = res;
      ein.rd            = rd;
      ein.branch_op     = op;
      ein.alu_zero      = z;
      ein.alu_a_bgt_b   = gt;
      ein.branch_target = tgt;
      ein.rs2_data      = sd;
      {ein.mem_read, ein.mem_write, ein.reg_write, ein.mem_to_reg} = ctl;
   endtask

   task automatic idle();
      set_in(64'd0, 5'd0, 2'b00, 1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
      ein.in_valid = 1'b0;
      ein.flush    = 1'b0;
   endtask

   // Hold the current offer until the stage takes it (bounded)
   task automatic send_wait();
      int n = 0;
      logic acc = 1'b0;
      do begin
         @(negedge clk);
         acc = ein.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 want accept within 200 cycles");
      end
      ein.in_valid = 1'b0;
   endtask

   task automatic rand_in();
      set_in({$urandom, $urandom}, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
             {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      ein.in_valid = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before 500us");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle();
      mout.out_ready = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();

      // 1: single entry, 1-cycle latency
      mout.out_ready = 1'b1;
      set_in(64'h5, 5'd3, BR_NONE, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0010);
      send_wait();
      chk("t1_out_valid", {63'd0, mout.out_valid}, 64'd1);
      chk("t1_out_result", mout.out_alu_result, 64'h5);
      chk("t1_out_rd", {59'd0, mout.out_rd}, 64'd3);
      chk("t1_in_ready", {63'd0, ein.in_ready}, 64'd1);
      cyc();

      // 2: stall fills main+skid, third offer waits, drains in order
      mout.out_ready = 1'b0;
      fork
         begin
            set_in(64'd1, 5'd1, BR_NONE, 1'b0, 1'b0, 64'd0, 64'd11, 4'b0010);
            send_wait();
            set_in(64'd2, 5'd2, BR_NONE, 1'b0, 1'b0, 64'd0, 64'd22, 4'b0100);
            send_wait();
            chk("t2_in_ready_full", {63'd0, ein.in_ready}, 64'd0);
            chk("t2_main_is_a", mout.out_alu_result, 64'd1);
            set_in(64'd3, 5'd3, BR_NONE, 1'b0, 1'b0, 64'd0, 64'd33, 4'b1001);
            send_wait();
         end
         begin
            repeat (6) cyc();
            mout.out_ready = 1'b1;
         end
      join
      repeat (4) cyc();

      // 3: branch pulses
      set_in(64'd7, 5'd0, BR_EQ, 1'b1, 1'b0, 64'h1000, 64'd0, 4'd0);
      send_wait();
      chk("t3_beq_pc_src", {63'd0, mout.pc_src}, 64'd1);
      chk("t3_beq_target", mout.pc_target, 64'h1000);
      cyc();
      chk("t3_beq_one_cycle", {63'd0, mout.pc_src}, 64'd0);
      set_in(64'd8, 5'd0, BR_NE, 1'b1, 1'b0, 64'h1100, 64'd0, 4'd0);
      send_wait();
      chk("t3_bne_not_taken", {63'd0, mout.pc_src}, 64'd0);
      set_in(64'd9, 5'd0, BR_GT, 1'b0, 1'b1, 64'h2000, 64'd0, 4'd0);
      send_wait();
      chk("t3_bgt_pc_src", {63'd0, mout.pc_src}, 64'd1);
      chk("t3_bgt_target", mout.pc_target, 64'h2000);
      repeat (2) cyc();

      // 4: flush from FULL, then flush of an acceptable taken branch
      mout.out_ready = 1'b0;
      set_in(64'd21, 5'd4, BR_NONE, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0010);
      send_wait();
      set_in(64'd22, 5'd5, BR_NONE, 1'b0, 1'b0, 64'd0, 64'd0, 4'b0010);
      send_wait();
      set_in(64'd23, 5'd6, BR_EQ, 1'b1, 1'b0, 64'h3000, 64'd0, 4'd0);
      ein.flush = 1'b1;
      cyc();
      idle();
      chk("t4_out_valid", {63'd0, mout.out_valid}, 64'd0);
      chk("t4_in_ready", {63'd0, ein.in_ready}, 64'd1);
      chk("t4_pc_src", {63'd0, mout.pc_src}, 64'd0);
      set_in(64'd24, 5'd7, BR_EQ, 1'b1, 1'b0, 64'h3100, 64'd0, 4'd0);
      ein.flush = 1'b1;
      cyc();
      idle();
      chk("t4b_pc_src", {63'd0, mout.pc_src}, 64'd0);
      chk("t4b_out_valid", {63'd0, mout.out_valid}, 64'd0);
      cyc();

      // 5: async reset while FULL and stalled
      set_in(64'd31, 5'd8, BR_NONE, 1'b0, 1'b0, 64'd0, 64'd5, 4'b0110);
      send_wait();
      set_in(64'd32, 5'd9, BR_NONE, 1'b0, 1'b0, 64'd0, 64'd6, 4'b0110);
      send_wait();
      reset = 1'b1;
      #1;
      chk("t5_out_valid", {63'd0, mout.out_valid}, 64'd0);
      chk("t5_in_ready", {63'd0, ein.in_ready}, 64'd1);
      chk("t5_out_result", mout.out_alu_result, 64'd0);
      repeat (2) cyc();
      reset = 1'b0;
      cyc();

`ifdef EX_MEM_PERF_EN
      // 6: three stall cycles and two taken branches after reset
      set_in(64'd41, 5'd1, BR_EQ, 1'b1, 1'b0, 64'h4000, 64'd0, 4'd0);
      send_wait();
      repeat (3) cyc();
      mout.out_ready = 1'b1;
      set_in(64'd42, 5'd2, BR_GT, 1'b0, 1'b1, 64'h4100, 64'd0, 4'd0);
      send_wait();
      repeat (3) cyc();
      chk("t6_stall_cnt", {32'd0, perf_stall_cnt}, 64'd3);
      chk("t6_taken_cnt", {32'd0, perf_taken_cnt}, 64'd2);
`endif

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         if (offer_done) rand_in();
         ein.flush      = ($urandom_range(0, 15) == 0);
         mout.out_ready = ($urandom_range(0, 2) != 0);
         cyc();
      end

      idle();
      mout.out_ready = 1'b1;
      repeat (5) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
